// File: rtl/imm_encoder.sv
// Immediate-field encoder: checks whether Value fits the ImmSrc format and packs it into Instr.
// Optional macro ROT_IMM_EN enables the multi-cycle rotated 8-bit search for mode 00.
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Value,
    input  logic [1:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] Instr,
    output logic        Fail
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    state_e      state_q;
    logic [31:0] value_q;
    logic [1:0]  src_q;
    logic [3:0]  rot_q;

    logic [4:0]  shamt;
    logic [31:0] rotv;
    logic        pass;
    logic [23:0] enc;

    // Rotate left by 2*rot; a shift of 32 yields zero, so rot=0 is the plain value.
    always_comb begin
        shamt = {rot_q, 1'b0};
        rotv  = (value_q << shamt) | (value_q >> (6'd32 - {1'b0, shamt}));
    end

    always_comb begin
        pass = 1'b0;
        enc  = 24'h0;
        case (src_q)
            2'b00: begin
                pass = (rotv[31:8] == 24'h0);
                enc  = {12'h0, rot_q, rotv[7:0]};
            end
            2'b01: begin
                pass = (value_q[31:12] == 20'h0);
                enc  = {12'h0, value_q[11:0]};
            end
            2'b10: begin
                // Offset must be word aligned and sign-extended from bit 25.
                pass = (value_q[1:0] == 2'b00) &&
                       ((&value_q[31:25]) || !(|value_q[31:25]));
                enc  = value_q[25:2];
            end
            default: begin
                pass = 1'b0;
                enc  = 24'h0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            value_q   <= 32'h0;
            src_q     <= 2'b00;
            rot_q     <= 4'h0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Instr     <= 24'h0;
            Fail      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        value_q  <= Value;
                        src_q    <= ImmSrc;
                        rot_q    <= 4'h0;
                        in_ready <= 1'b0;
                        state_q  <= StEval;
                    end
                end
                StEval: begin
`ifdef ROT_IMM_EN
                    if (src_q == 2'b00 && !pass && rot_q != 4'hF) begin
                        rot_q <= rot_q + 4'h1;
                    end else begin
                        Instr     <= pass ? enc : 24'h0;
                        Fail      <= !pass;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
`else
                    Instr     <= pass ? enc : 24'h0;
                    Fail      <= !pass;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder; expectations follow ROT_IMM_EN when defined.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] Value;
    logic [1:0]  ImmSrc;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] Instr;
    logic        Fail;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Value     (Value),
        .ImmSrc    (ImmSrc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Instr     (Instr),
        .Fail      (Fail)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; lat is the edge (acceptance = edge 1) after which out_valid must be seen.
    task automatic run(input string tag, input logic [1:0] src, input logic [31:0] val,
                       input int lat, input logic [23:0] ei, input logic ef);
        int n;
        bit seen;
        @(negedge clk);
        check({tag, " in_ready"}, {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        Value    = val;
        ImmSrc   = src;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        Value    = ~val;
        ImmSrc   = ~src;
        n        = 1;
        seen     = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) seen = 1'b1;
        end
        check({tag, " latency"}, seen ? n : 0, lat);
        check({tag, " instr"}, {8'h0, Instr}, {8'h0, ei});
        check({tag, " fail"}, {31'h0, Fail}, {31'h0, ef});
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " release"}, {31'h0, out_valid}, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Value     = 32'h0;
        ImmSrc    = 2'b00;
        #12;
        check("rst in_ready", {31'h0, in_ready}, 32'h1);
        check("rst out_valid", {31'h0, out_valid}, 32'h0);
        check("rst instr", {8'h0, Instr}, 32'h0);
        check("rst fail", {31'h0, Fail}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("m00 ab", 2'b00, 32'h0000_00AB, 2, 24'h0000AB, 1'b0);
`ifdef ROT_IMM_EN
        run("m00 ff000000", 2'b00, 32'hFF00_0000, 6, 24'h0004FF, 1'b0);
        run("m00 101", 2'b00, 32'h0000_0101, 17, 24'h0, 1'b1);
        run("m00 3f0", 2'b00, 32'h0000_03F0, 16, 24'h000E3F, 1'b0);
`else
        run("m00 ff000000", 2'b00, 32'hFF00_0000, 2, 24'h0, 1'b1);
        run("m00 101", 2'b00, 32'h0000_0101, 2, 24'h0, 1'b1);
        run("m00 3f0", 2'b00, 32'h0000_03F0, 2, 24'h0, 1'b1);
`endif
        run("m10 fffffff8", 2'b10, 32'hFFFF_FFF8, 2, 24'hFFFFFE, 1'b0);
        run("m10 6", 2'b10, 32'h0000_0006, 2, 24'h0, 1'b1);
        run("m10 2000000", 2'b10, 32'h0200_0000, 2, 24'h0, 1'b1);
        run("m11", 2'b11, 32'h0000_0000, 2, 24'h0, 1'b1);
        run("m01 1000", 2'b01, 32'h0000_1000, 2, 24'h0, 1'b1);
        run("m01 fff", 2'b01, 32'h0000_0FFF, 2, 24'h000FFF, 1'b0);

        // Backpressure in DONE with a competing request on in_valid.
        @(negedge clk);
        in_valid = 1'b1;
        Value    = 32'h0000_0123;
        ImmSrc   = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp done", {31'h0, out_valid}, 32'h1);
        in_valid = 1'b1;
        Value    = 32'h0000_00AB;
        ImmSrc   = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", {31'h0, out_valid}, 32'h1);
            check("bp instr", {8'h0, Instr}, 32'h0000_0123);
            check("bp fail", {31'h0, Fail}, 32'h0);
            check("bp in_ready", {31'h0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp exit out_valid", {31'h0, out_valid}, 32'h0);
        check("bp exit in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("bp no accept", {31'h0, in_ready}, 32'h1);

        // Asynchronous reset mid-EVAL; Instr still holds 0x123 from the last result.
        @(negedge clk);
        in_valid = 1'b1;
        Value    = 32'h0000_0101;
        ImmSrc   = 2'b00;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("mid in_ready", {31'h0, in_ready}, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst in_ready", {31'h0, in_ready}, 32'h1);
        check("arst out_valid", {31'h0, out_valid}, 32'h0);
        check("arst instr", {8'h0, Instr}, 32'h0);
        check("arst fail", {31'h0, Fail}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run("post rst", 2'b10, 32'hFFFF_FFF8, 2, 24'hFFFFFE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
